itcm_boot_loader: RTL

//  Streams a program image into the 64-bit-wide ITCM before the core runs and holds the core in reset until the load completes.

---
 rtl/itcm_boot_loader.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/itcm_boot_loader.sv
// itcm_boot_loader: streams a length-prefixed byte image into the 64-bit ITCM and holds the core in reset until the load completes.
// Optional feature macro: ITCM_BOOT_CSUM_EN adds a trailing mod-256 checksum byte after the data.
module itcm_boot_loader #(
    parameter int ITCM_SIZE = 16384,
    parameter int ADDR_W    = 11
) (
    input  logic              clk,
    input  logic              cpurst_n,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    input  logic              reload,
    output logic              itcm_we,
    output logic [ADDR_W-1:0] itcm_addr,
    output logic [63:0]       itcm_wdata,
    output logic [7:0]        itcm_wmask,
    output logic              core_rst,
    output logic              done,
    output logic              err
);
`ifdef ITCM_BOOT_CSUM_EN
    typedef enum logic [2:0] {S_LEN, S_DATA, S_CSUM, S_DONE, S_ERR} state_t;
    logic [7:0]  sum;
`else
    typedef enum logic [2:0] {S_LEN, S_DATA, S_DONE, S_ERR} state_t;
`endif
    state_t      state;
    logic [1:0]  lcnt;
    logic [31:0] len;
    logic [31:0] cnt;
    logic [63:0] acc;
    logic [7:0]  mask;
    logic        hs;
    logic        last;
    logic [31:0] len_nxt;
    logic [31:0] cnt_nxt;
    logic [63:0] acc_nxt;
    logic [7:0]  mask_nxt;

    assign hs       = rx_valid & rx_ready;
    assign len_nxt  = {rx_data, len[31:8]};
    assign cnt_nxt  = cnt + 32'd1;
    assign last     = cnt_nxt == len;
    assign acc_nxt  = acc | (64'(rx_data) << {cnt[2:0], 3'b000});
    assign mask_nxt = mask | (8'd1 << cnt[2:0]);

    // Frame sequencer: length capture, word packing, optional checksum, terminal done/error states.
    always_ff @(posedge clk or negedge cpurst_n) begin
        if (!cpurst_n) begin
            state      <= S_LEN;
            lcnt       <= '0;
            len        <= '0;
            cnt        <= '0;
            acc        <= '0;
            mask       <= '0;
`ifdef ITCM_BOOT_CSUM_EN
            sum        <= '0;
`endif
            rx_ready   <= 1'b0;
            itcm_we    <= 1'b0;
            itcm_addr  <= '0;
            itcm_wdata <= '0;
            itcm_wmask <= '0;
            core_rst   <= 1'b1;
            done       <= 1'b0;
            err        <= 1'b0;
        end else if (reload) begin
            state      <= S_LEN;
            lcnt       <= '0;
            len        <= '0;
            cnt        <= '0;
            acc        <= '0;
            mask       <= '0;
`ifdef ITCM_BOOT_CSUM_EN
            sum        <= '0;
`endif
            rx_ready   <= 1'b1;
            itcm_we    <= 1'b0;
            core_rst   <= 1'b1;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            itcm_we <= 1'b0;
            case (state)
                S_LEN: begin
                    rx_ready <= 1'b1;
                    if (hs) begin
                        len  <= len_nxt;
                        lcnt <= lcnt + 2'd1;
                        if (lcnt == 2'd3) begin
                            if (len_nxt > 32'(ITCM_SIZE)) begin
                                state    <= S_ERR;
                                rx_ready <= 1'b0;
                            end else if (len_nxt == 32'd0) begin
`ifdef ITCM_BOOT_CSUM_EN
                                state    <= S_CSUM;
`else
                                state    <= S_DONE;
                                rx_ready <= 1'b0;
`endif
                            end else begin
                                state <= S_DATA;
                            end
                        end
                    end
                end
                S_DATA: begin
                    if (hs) begin
                        cnt <= cnt_nxt;
`ifdef ITCM_BOOT_CSUM_EN
                        sum <= sum + rx_data;
`endif
                        if (cnt[2:0] == 3'd7 || last) begin
                            itcm_we    <= 1'b1;
                            itcm_addr  <= cnt[ADDR_W+2:3];
                            itcm_wdata <= acc_nxt;
                            itcm_wmask <= mask_nxt;
                            acc        <= '0;
                            mask       <= '0;
                        end else begin
                            acc  <= acc_nxt;
                            mask <= mask_nxt;
                        end
                        if (last) begin
`ifdef ITCM_BOOT_CSUM_EN
                            state    <= S_CSUM;
`else
                            state    <= S_DONE;
                            rx_ready <= 1'b0;
`endif
                        end
                    end
                end
`ifdef ITCM_BOOT_CSUM_EN
                S_CSUM: begin
                    if (hs) begin
                        state    <= (rx_data == sum) ? S_DONE : S_ERR;
                        rx_ready <= 1'b0;
                    end
                end
`endif
                S_DONE: begin
                    done     <= 1'b1;
                    core_rst <= 1'b0;
                end
                S_ERR: begin
                    err <= 1'b1;
                end
                default: begin
                    state <= S_ERR;
                end
            endcase
        end
    end
endmodule
